// File: rtl/mcu_spi_pkg.sv
// Shared types and helpers for the MCU SPI port selector.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        GUARD = 2'd2
    } sel_state_t;

    // Port index width; never zero so a single-port build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-bit flop chain that brings asynchronous select lines into the clock domain.
module sync_bus #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= RESET_VAL;
                    else     stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= RESET_VAL;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/mcu_spi_port_select.sv
// Arbitrates several board SPI ports onto the single core MCU interface by chip select,
// holding one owner per transfer until its select has been idle for a guard time.
module mcu_spi_port_select
    import mcu_spi_pkg::*;
#(
    parameter int NPORTS       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 32,
    parameter int DEFAULT_PORT = 0,
    localparam int IW          = idx_width(NPORTS)
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              fixed_mode,
    input  logic [IW-1:0]     fixed_sel,
    input  logic [NPORTS-1:0] port_sclk,
    input  logic [NPORTS-1:0] port_ss_n,
    input  logic [NPORTS-1:0] port_mosi,
    output logic [NPORTS-1:0] port_miso,
    output logic [NPORTS-1:0] port_miso_oe,
    output logic [NPORTS-1:0] port_intn,
    output logic              mcu_sclk,
    output logic              mcu_csn,
    output logic              mcu_mosi,
    input  logic              mcu_miso,
    input  logic              mcu_intn,
    output logic [IW-1:0]     owner,
    output logic              locked,
    output logic              collision
);

    localparam int            CW       = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] HOME     = IW'(DEFAULT_PORT);
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);

    sel_state_t        state_reg;
    logic [IW-1:0]     owner_reg;
    logic              locked_reg;
    logic              collision_reg;
    logic [CW-1:0]     cnt_reg;
    logic [NPORTS-1:0] intn_reg;

    logic [NPORTS-1:0] ss_s;
    logic [NPORTS-1:0] owner_onehot;
    logic [NPORTS-1:0] route_sel;
    logic [NPORTS-1:0] intn_next;
    logic              req_found;
    logic [IW-1:0]     req_idx;
    logic              others_req;

    sync_bus #(
        .WIDTH     (NPORTS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({NPORTS{1'b1}})
    ) u_ss_sync (
        .clk (clk32),
        .rst (reset),
        .d   (port_ss_n),
        .q   (ss_s)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
            assign route_sel[gi]    = locked_reg & owner_onehot[gi];
            assign port_miso[gi]    = route_sel[gi] & mcu_miso;
            assign port_miso_oe[gi] = route_sel[gi];
        end
    endgenerate

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        req_found = 1'b0;
        req_idx   = HOME;
        if (fixed_mode) begin
            if (int'(fixed_sel) < NPORTS && !ss_s[fixed_sel]) begin
                req_found = 1'b1;
                req_idx   = fixed_sel;
            end
        end else begin
            for (int k = NPORTS - 1; k >= 0; k--) begin
                if (!ss_s[k]) begin
                    req_found = 1'b1;
                    req_idx   = IW'(k);
                end
            end
        end
    end

    assign others_req = |(~ss_s & ~owner_onehot);
    assign intn_next  = mcu_intn ? {NPORTS{1'b1}} : ~owner_onehot;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= HOME;
            locked_reg    <= 1'b0;
            collision_reg <= 1'b0;
            cnt_reg       <= '0;
            intn_reg      <= {NPORTS{1'b1}};
        end else begin
            intn_reg <= intn_next;
            if (locked_reg && others_req) collision_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (req_found) begin
                        state_reg  <= OWN;
                        owner_reg  <= req_idx;
                        locked_reg <= 1'b1;
                    end
                end
                OWN: begin
                    if (ss_s[owner_reg]) begin
                        state_reg <= GUARD;
                        cnt_reg   <= '0;
                    end
                end
                GUARD: begin
                    if (!ss_s[owner_reg]) begin
                        state_reg <= OWN;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    // Raw (unsynchronised) select and data follow the owner so the core sees exact SPI timing.
    assign mcu_csn   = locked_reg ? port_ss_n[owner_reg] : 1'b1;
    assign mcu_sclk  = locked_reg & port_sclk[owner_reg];
    assign mcu_mosi  = locked_reg & port_mosi[owner_reg];
    assign owner     = owner_reg;
    assign locked    = locked_reg;
    assign collision = collision_reg;
    assign port_intn = intn_reg;

endmodule

// File: tb/tb_mcu_spi_port_select.sv
// Directed and randomized checks of the SPI port selector against a transfer-level model.
module tb_mcu_spi_port_select;

    localparam int NP   = 2;
    localparam int SYNC = 2;
    localparam int TO   = 32;
    localparam int HOME = 0;

    logic          clk32 = 1'b0;
    logic          reset = 1'b1;
    logic          fixed_mode = 1'b0;
    logic [0:0]    fixed_sel = 1'b0;
    logic [NP-1:0] port_sclk = '0;
    logic [NP-1:0] port_ss_n = '1;
    logic [NP-1:0] port_mosi = '0;
    logic [NP-1:0] port_miso;
    logic [NP-1:0] port_miso_oe;
    logic [NP-1:0] port_intn;
    logic          mcu_sclk, mcu_csn, mcu_mosi;
    logic          mcu_miso = 1'b0;
    logic          mcu_intn = 1'b1;
    logic [0:0]    owner;
    logic          locked, collision;

    int checks = 0;
    int errors = 0;

    mcu_spi_port_select #(
        .NPORTS(NP), .SYNC_STAGES(SYNC), .IDLE_TIMEOUT(TO), .DEFAULT_PORT(HOME)
    ) dut (
        .clk32(clk32), .reset(reset), .fixed_mode(fixed_mode), .fixed_sel(fixed_sel),
        .port_sclk(port_sclk), .port_ss_n(port_ss_n), .port_mosi(port_mosi),
        .port_miso(port_miso), .port_miso_oe(port_miso_oe), .port_intn(port_intn),
        .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn), .mcu_mosi(mcu_mosi),
        .mcu_miso(mcu_miso), .mcu_intn(mcu_intn),
        .owner(owner), .locked(locked), .collision(collision)
    );

    always #5 clk32 = ~clk32;

    // Reference model: who owns the core, how long its select has been seen idle.
    bit            m_locked;
    int            m_owner;
    int            m_high_run;
    bit            m_coll;
    logic [NP-1:0] m_intn;
    logic [NP-1:0] hist[$];

    // Core-side byte capture (SPI mode 0, MSB first).
    bit         cap_en = 1'b0;
    logic [7:0] sh = '0;
    int         nb = 0;
    logic [7:0] got[$];
    logic [7:0] tx[16];

    always @(posedge mcu_sclk) begin
        if (cap_en && !mcu_csn) begin
            if (nb == 7) begin
                got.push_back({sh[6:0], mcu_mosi});
                nb <= 0;
            end else begin
                nb <= nb + 1;
            end
            sh <= {sh[6:0], mcu_mosi};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_owner    = HOME;
        m_high_run = 0;
        m_coll     = 1'b0;
        m_intn     = '1;
        hist       = {};
        for (int i = 0; i < SYNC; i++) hist.push_back('1);
    endtask

    // Called right at a rising edge, before any input changes.
    task automatic model_edge();
        logic [NP-1:0] ss_s;
        logic [NP-1:0] new_intn;
        bit            found;
        if (reset) begin
            model_reset();
        end else begin
            ss_s = hist.pop_front();
            hist.push_back(port_ss_n);
            new_intn = '1;
            new_intn[m_owner] = mcu_intn;
            if (m_locked) begin
                for (int k = 0; k < NP; k++)
                    if (k != m_owner && !ss_s[k]) m_coll = 1'b1;
                if (!ss_s[m_owner]) begin
                    m_high_run = 0;
                end else begin
                    m_high_run++;
                    if (m_high_run == TO + 1) begin
                        m_locked   = 1'b0;
                        m_high_run = 0;
                    end
                end
            end else if (fixed_mode) begin
                if (!ss_s[fixed_sel]) begin
                    m_locked = 1'b1;
                    m_owner  = int'(fixed_sel);
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    if (!found && !ss_s[k]) begin
                        found    = 1'b1;
                        m_locked = 1'b1;
                        m_owner  = k;
                    end
                end
            end
            m_intn = new_intn;
        end
    endtask

    task automatic check_comb();
        logic [NP-1:0] exp_oe, exp_miso;
        exp_oe   = '0;
        exp_miso = '0;
        if (m_locked) begin
            exp_oe[m_owner]   = 1'b1;
            exp_miso[m_owner] = mcu_miso;
        end
        chk("mcu_csn",  mcu_csn,  m_locked ? port_ss_n[m_owner] : 1'b1);
        chk("mcu_sclk", mcu_sclk, m_locked ? port_sclk[m_owner] : 1'b0);
        chk("mcu_mosi", mcu_mosi, m_locked ? port_mosi[m_owner] : 1'b0);
        chk("miso_oe",  port_miso_oe, exp_oe);
        chk("miso",     port_miso, exp_miso);
    endtask

    task automatic check_regs();
        chk("locked",    locked, m_locked);
        chk("owner",     owner, m_owner);
        chk("collision", collision, m_coll);
        chk("intn",      port_intn, m_intn);
    endtask

    // One clock: random core-side inputs, check routing, advance, check state.
    task automatic tick();
        mcu_miso = 1'($urandom);
        mcu_intn = 1'($urandom);
        #1;
        check_comb();
        @(posedge clk32);
        model_edge();
        #1;
        check_regs();
        check_comb();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        ticks(3);
        chk("reset_csn", mcu_csn, 1'b1);
        chk("reset_oe", port_miso_oe, 2'b00);
        chk("reset_owner", owner, HOME);
        chk("reset_intn", port_intn, 2'b11);
        reset = 1'b0;
        ticks(3);

        // Port 1 transfer of 16 bytes in auto mode.
        port_ss_n = 2'b01;
        ticks(SYNC);
        chk("lock_not_early", locked, 1'b0);
        tick();
        chk("lock_latency", locked, 1'b1);
        chk("xfer_oe", port_miso_oe, 2'b10);
        tick();
        cap_en = 1'b1;
        for (int b = 0; b < 16; b++) begin
            tx[b] = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                port_mosi[1] = tx[b][i];
                tick();
                port_sclk[1] = 1'b1;
                tick();
                port_sclk[1] = 1'b0;
                tick();
            end
        end
        cap_en = 1'b0;
        chk("byte_count", got.size(), 16);
        for (int b = 0; b < 16 && b < got.size(); b++) chk("byte", got[b], tx[b]);
        port_ss_n = 2'b11;
        ticks(SYNC + TO);
        chk("guard_hold", locked, 1'b1);
        tick();
        chk("released", locked, 1'b0);
        chk("owner_kept", owner, 1);
        ticks(3);

        // Simultaneous request: port 0 wins, port 1 traffic flags a collision.
        port_ss_n = 2'b00;
        for (int i = 0; i < 30; i++) begin
            port_sclk[1] = ~port_sclk[1];
            port_mosi[1] = 1'($urandom);
            tick();
        end
        chk("tie_owner", owner, 0);
        chk("tie_collision", collision, 1'b1);
        port_ss_n = 2'b11;
        port_sclk = '0;
        ticks(SYNC + TO + 4);

        // Short gap below the guard time keeps ownership.
        port_ss_n = 2'b10;
        ticks(8);
        port_ss_n = 2'b11;
        ticks(10);
        port_ss_n = 2'b10;
        ticks(8);
        chk("gap_locked", locked, 1'b1);

        // Reset in the middle of a byte.
        port_sclk[0] = 1'b1;
        port_mosi[0] = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        check_regs();
        check_comb();
        chk("abort_csn", mcu_csn, 1'b1);
        ticks(2);
        reset = 1'b0;
        port_sclk = '0;
        port_mosi = '0;
        ticks(SYNC + 3);
        chk("recover_locked", locked, 1'b1);
        port_ss_n = 2'b11;
        ticks(SYNC + TO + 4);

        // Fixed mode on port 1: port 0 is ignored while idle.
        fixed_mode = 1'b1;
        fixed_sel  = 1'b1;
        port_ss_n  = 2'b10;
        ticks(10);
        chk("fixed_ignore", locked, 1'b0);
        chk("fixed_no_coll", collision, 1'b0);
        port_ss_n = 2'b01;
        ticks(SYNC + 3);
        fixed_sel = 1'b0;
        ticks(6);
        chk("fixed_owner", owner, 1);
        port_ss_n = 2'b10;
        ticks(SYNC + TO + 4);
        chk("fixed_switched", owner, 0);
        port_ss_n = 2'b11;
        ticks(SYNC + TO + 4);

        // Randomized traffic with slowly changing selects.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NP; k++)
                if ($urandom_range(0, 11) == 0) port_ss_n[k] = ~port_ss_n[k];
            port_sclk = NP'($urandom);
            port_mosi = NP'($urandom);
            if ($urandom_range(0, 199) == 0) fixed_mode = ~fixed_mode;
            if ($urandom_range(0, 99) == 0) fixed_sel = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
